// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream program loader writing 32-bit words into instruction memory
// Optional trailing XOR checksum enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_loader #(
   parameter int INST_MEM_WIDTH = 15
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic [INST_MEM_WIDTH-1:0] mem_addr,
   output logic [31:0]               mem_din,
   output logic                      mem_we,
   output logic                      loading,
   output logic                      loader_ready,
   output logic                      error
);

`ifdef INST_LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {HEADER = 2'd0, DATA = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {HEADER = 2'd0, DATA = 2'd1, DONE = 2'd3} state_t;
`endif

   state_t                    state, state_n;
   logic [1:0]                byte_pos, byte_pos_n;
   logic [23:0]               shift, shift_n;
   logic [31:0]               word_idx, word_idx_n;
   logic [31:0]               word_cnt, word_cnt_n;
   logic [INST_MEM_WIDTH-1:0] addr_n;
   logic [31:0]               din_n;
   logic                      we_n, loading_n, ready_n, error_n;
   logic                      finish;
   logic                      last_byte;
   logic [31:0]               assembled;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [31:0]               acc, acc_n;
`endif

   assign assembled = {shift, rx_data};
   assign last_byte = (byte_pos == 2'd3);

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state        <= HEADER;
         byte_pos     <= 2'd0;
         shift        <= 24'd0;
         word_idx     <= 32'd0;
         word_cnt     <= 32'd0;
         mem_addr     <= '0;
         mem_din      <= 32'd0;
         mem_we       <= 1'b0;
         loading      <= 1'b0;
         loader_ready <= 1'b0;
         error        <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
         acc          <= 32'd0;
`endif
      end else begin
         state        <= state_n;
         byte_pos     <= byte_pos_n;
         shift        <= shift_n;
         word_idx     <= word_idx_n;
         word_cnt     <= word_cnt_n;
         mem_addr     <= addr_n;
         mem_din      <= din_n;
         mem_we       <= we_n;
         loading      <= loading_n;
         loader_ready <= ready_n;
         error        <= error_n;
`ifdef INST_LOADER_CHECKSUM_EN
         acc          <= acc_n;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      byte_pos_n = byte_pos;
      shift_n    = shift;
      word_idx_n = word_idx;
      word_cnt_n = word_cnt;
      addr_n     = mem_addr;
      din_n      = mem_din;
      we_n       = 1'b0;
      loading_n  = loading;
      ready_n    = 1'b0;
      error_n    = error;
      finish     = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      acc_n      = acc;
`endif

      if (rx_valid && state != DONE) begin
         shift_n    = {shift[15:0], rx_data};
         byte_pos_n = byte_pos + 2'd1;
      end

      case (state)
         HEADER: begin
            if (rx_valid) begin
               loading_n = 1'b1;
               if (last_byte) begin
                  word_cnt_n = assembled;
                  word_idx_n = 32'd0;
                  if (assembled == 32'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                     state_n = CHECK;
`else
                     finish  = 1'b1;
`endif
                  end else begin
                     state_n = DATA;
                  end
               end
            end
         end
         DATA: begin
            if (rx_valid && last_byte) begin
               // Words past the end of memory are consumed but never written.
               if ((word_idx >> INST_MEM_WIDTH) == 32'd0) begin
                  we_n   = 1'b1;
                  addr_n = word_idx[INST_MEM_WIDTH-1:0];
                  din_n  = assembled;
               end else begin
                  error_n = 1'b1;
               end
`ifdef INST_LOADER_CHECKSUM_EN
               acc_n = acc ^ assembled;
`endif
               word_idx_n = word_idx + 32'd1;
               if (word_idx == word_cnt - 32'd1) begin
`ifdef INST_LOADER_CHECKSUM_EN
                  state_n = CHECK;
`else
                  finish  = 1'b1;
`endif
               end
            end
         end
`ifdef INST_LOADER_CHECKSUM_EN
         CHECK: begin
            if (rx_valid && last_byte) begin
               if (assembled != acc) error_n = 1'b1;
               finish = 1'b1;
            end
         end
`endif
         default: ;
      endcase

      // error_n already includes any fault detected on this final byte.
      if (finish) begin
         state_n   = DONE;
         loading_n = 1'b0;
         ready_n   = !error_n;
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed self-checking bench for inst_loader
// Honours INST_LOADER_CHECKSUM_EN when appending checksum bytes and choosing expectations.
module tb_inst_loader;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;

   logic [14:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_we, loading, loader_ready, error;
   logic [1:0]  sm_addr_w;
   logic [31:0] sm_din;
   logic        sm_we, sm_loading, sm_ready, sm_error;

   inst_loader u_dut (
      .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .loading(loading), .loader_ready(loader_ready), .error(error)
   );

   inst_loader #(.INST_MEM_WIDTH(2)) u_small (
      .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .mem_addr(sm_addr_w), .mem_din(sm_din), .mem_we(sm_we),
      .loading(sm_loading), .loader_ready(sm_ready), .error(sm_error)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int gap_mode = 0;
   int gap_seq = 0;

   logic [31:0] wr_addr [16];
   logic [31:0] wr_data [16];
   logic [31:0] sm_addr [16];
   logic [31:0] sm_data [16];
   int wr_n, sm_n, rdy_n, sm_rdy_n, rdy_bad, rdy_cyc, last_rx;
   logic prev_loading = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (rx_valid) last_rx = cyc;
      if (mem_we && wr_n < 16) begin
         wr_addr[wr_n] = {17'd0, mem_addr};
         wr_data[wr_n] = mem_din;
         wr_n++;
      end
      if (sm_we && sm_n < 16) begin
         sm_addr[sm_n] = {30'd0, sm_addr_w};
         sm_data[sm_n] = sm_din;
         sm_n++;
      end
      if (loader_ready) begin
         rdy_n++;
         rdy_cyc = cyc;
         if (loading !== 1'b0 || prev_loading !== 1'b1) rdy_bad++;
      end
      if (sm_ready) sm_rdy_n++;
      prev_loading = loading;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_mon();
      wr_n = 0; sm_n = 0; rdy_n = 0; sm_rdy_n = 0; rdy_bad = 0; rdy_cyc = -1; last_rx = -100;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      rx_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      clear_mon();
   endtask

   task automatic send_byte(input logic [7:0] b);
      if (gap_mode != 0) begin
         repeat (gap_seq % 8) tick();
         gap_seq++;
      end
      rx_data = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic send_two_word_stream(input logic [31:0] csum);
      send_word(32'h0000_0002);
      send_word(32'h0800_0000);
      send_word(32'hDEAD_BEEF);
`ifdef INST_LOADER_CHECKSUM_EN
      send_word(csum);
`else
      if (csum != 32'd0) rx_data = 8'd0;
`endif
   endtask

   task automatic check_two_words(input string tag);
      check({tag, "_wr_n"}, wr_n, 32'd2);
      check({tag, "_addr0"}, wr_addr[0], 32'd0);
      check({tag, "_data0"}, wr_data[0], 32'h0800_0000);
      check({tag, "_addr1"}, wr_addr[1], 32'd1);
      check({tag, "_data1"}, wr_data[1], 32'hDEAD_BEEF);
      check({tag, "_rdy_n"}, rdy_n, 32'd1);
      check({tag, "_rdy_lat"}, rdy_cyc - last_rx, 32'd1);
      check({tag, "_rdy_edge"}, rdy_bad, 32'd0);
      check({tag, "_error"}, {31'd0, error}, 32'd0);
      check({tag, "_loading"}, {31'd0, loading}, 32'd0);
   endtask

   initial begin
      clear_mon();
      tick();
      tick();
      check("rst_we", {31'd0, mem_we}, 32'd0);
      check("rst_loading", {31'd0, loading}, 32'd0);
      check("rst_ready", {31'd0, loader_ready}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_addr", {17'd0, mem_addr}, 32'd0);
      check("rst_din", mem_din, 32'd0);
      reset = 1'b1;
      clear_mon();

      send_byte(8'h00);
      check("loading_rise", {31'd0, loading}, 32'd1);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h02);
      send_word(32'h0800_0000);
      send_word(32'hDEAD_BEEF);
`ifdef INST_LOADER_CHECKSUM_EN
      send_word(32'hD6AD_BEEF);
`endif
      repeat (3) tick();
      check_two_words("base");

      send_word(32'h1234_5678);
      repeat (3) tick();
      check("after_done_wr_n", wr_n, 32'd2);
      check("after_done_rdy_n", rdy_n, 32'd1);

`ifdef INST_LOADER_CHECKSUM_EN
      do_reset();
      send_two_word_stream(32'h0000_0000);
      repeat (3) tick();
      check("badsum_wr_n", wr_n, 32'd2);
      check("badsum_error", {31'd0, error}, 32'd1);
      check("badsum_rdy_n", rdy_n, 32'd0);
`endif

      do_reset();
      gap_mode = 1;
      send_two_word_stream(32'hD6AD_BEEF);
      gap_mode = 0;
      repeat (3) tick();
      check_two_words("gaps");

      do_reset();
      send_word(32'h0000_0000);
`ifdef INST_LOADER_CHECKSUM_EN
      send_word(32'h0000_0000);
`endif
      repeat (3) tick();
      check("zero_wr_n", wr_n, 32'd0);
      check("zero_rdy_n", rdy_n, 32'd1);
      check("zero_rdy_lat", rdy_cyc - last_rx, 32'd1);
      check("zero_error", {31'd0, error}, 32'd0);

      do_reset();
      send_word(32'h0000_0005);
      send_word(32'h1111_1111);
      send_word(32'h2222_2222);
      send_word(32'h3333_3333);
      send_word(32'h4444_4444);
      send_word(32'h5555_5555);
`ifdef INST_LOADER_CHECKSUM_EN
      send_word(32'h1111_1111);
`endif
      repeat (3) tick();
      check("small_wr_n", sm_n, 32'd4);
      check("small_addr0", sm_addr[0], 32'd0);
      check("small_data0", sm_data[0], 32'h1111_1111);
      check("small_addr3", sm_addr[3], 32'd3);
      check("small_data3", sm_data[3], 32'h4444_4444);
      check("small_error", {31'd0, sm_error}, 32'd1);
      check("small_rdy_n", sm_rdy_n, 32'd0);
      check("small_loading", {31'd0, sm_loading}, 32'd0);

      do_reset();
      send_word(32'h0000_0002);
      send_word(32'h0800_0000);
      send_byte(8'hAB);
      send_byte(8'hCD);
      do_reset();
      check("midrst_loading", {31'd0, loading}, 32'd0);
      send_word(32'h0000_0001);
      send_word(32'hCAFE_F00D);
`ifdef INST_LOADER_CHECKSUM_EN
      send_word(32'hCAFE_F00D);
`endif
      repeat (3) tick();
      check("midrst_wr_n", wr_n, 32'd1);
      check("midrst_addr0", wr_addr[0], 32'd0);
      check("midrst_data0", wr_data[0], 32'hCAFE_F00D);
      check("midrst_rdy_n", rdy_n, 32'd1);
      check("midrst_error", {31'd0, error}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 The module SHALL have parameter INST_MEM_WIDTH, default 15, giving the instruction-memory address width (depth 2^INST_MEM_WIDTH words).
REQ-002 The module SHALL have port CLK  input  1  single clock; all logic on posedge CLK.
REQ-003 The module SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets on posedge CLK).
REQ-004 The module SHALL have port rx_data  input  8  received program byte.
REQ-005 The module SHALL have port rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-006 The module SHALL have port mem_addr  output  INST_MEM_WIDTH  instruction-memory write address.
REQ-007 The module SHALL have port mem_din  output  32  instruction-memory write data.
REQ-008 The module SHALL have port mem_we  output  1  instruction-memory write enable, one cycle per word.
REQ-009 The module SHALL have port loading  output  1  level; high from the first byte accepted until DONE.
REQ-010 The module SHALL have port loader_ready  output  1  one-cycle pulse on load completion.
REQ-011 The module SHALL have port error  output  1  sticky error flag; clears only on reset.

Function
REQ-012 The module SHALL implement states HEADER, DATA, CHECK, DONE; reset state HEADER.
REQ-013 The module SHALL assemble bytes big-endian: 1st byte of a word -> bits 31:24, 4th -> bits 7:0.
REQ-014 The module SHALL, in HEADER, take the first 4 bytes as word count N (32-bit unsigned), then go to DATA, or, if N==0, go directly to CHECK (macro on) or DONE (macro off).
REQ-015 The module SHALL, in DATA, write each assembled word: mem_we=1 for exactly one cycle, the cycle after the rx_valid carrying the word's 4th byte, with mem_addr = word index (0..N-1) and mem_din = the word.
REQ-016 The module SHALL, when word index >= 2^INST_MEM_WIDTH, keep mem_we=0 for that word, still consume its bytes, and set error.
REQ-017 The module SHALL, after the Nth word, go to CHECK (macro on) or DONE (macro off).
REQ-018 The module SHALL assert loader_ready for exactly one cycle on entry to DONE, coincident with loading falling, and only when error==0.
REQ-019 The module SHALL, in DONE, ignore rx_valid, hold mem_we=0, and stay in DONE until reset.
REQ-020 The module SHALL ignore cycles with rx_valid==0: byte position, word index and state are held.
REQ-021 The module SHALL raise loading on the cycle after the first accepted rx_valid in HEADER.
REQ-022 The module SHALL keep mem_addr and mem_din stable while mem_we==0; their values are don't-care to memory.

Reset
REQ-023 The module SHALL, on reset==0 at posedge CLK, set state=HEADER, byte position=0, word index=0, mem_addr=0, mem_din=0, mem_we=0, loading=0, loader_ready=0, error=0, and checksum accumulator=0.
REQ-024 The module SHALL abandon any partial header, word or checksum on a reset asserted mid-load, with no write issued for the partial word.

Configuration
REQ-025 The module SHALL, with INST_LOADER_CHECKSUM_EN defined, XOR-accumulate every DATA word (including dropped ones), receive a 4-byte big-endian checksum in CHECK, and then enter DONE, setting error if checksum != accumulator (loader_ready then suppressed).
REQ-026 The module SHALL, without INST_LOADER_CHECKSUM_EN, omit the CHECK state and the accumulator entirely, and transition DATA->DONE after the Nth word.

Verification
REQ-027 The bench SHALL cover: header 00 00 00 02, bytes 08 00 00 00 DE AD BE EF -> writes (0,0x08000000) and (1,0xDEADBEEF), then a single-cycle loader_ready (macro off).
REQ-028 The bench SHALL cover: same stream plus checksum D6 AD BE EF, macro on -> loader_ready pulse, error=0; checksum 00 00 00 00 -> error=1, no loader_ready.
REQ-029 The bench SHALL cover: header 00 00 00 00 -> no mem_we, loader_ready one cycle after the 4th header byte (macro off).
REQ-030 The bench SHALL cover: INST_MEM_WIDTH=2, N=5 -> writes at addresses 0..3 only, 5th word not written, error=1, no loader_ready.
REQ-031 The bench SHALL cover: reset pulled low after 2 bytes of word 1 in DATA, then a fresh stream with N=1 -> exactly one write at address 0 with the new word.
REQ-032 The bench SHALL cover: rx_valid gaps of 0..7 idle cycles between bytes -> identical writes and timing relative to the final rx_valid; bytes arriving after DONE -> no mem_we.
